seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports a, b  input  DATA_WIDTH  operands.
REQ-005 SHALL have port op  input  4  operation select.
REQ-006 SHALL have port start  input  1  launches the multi-cycle op on op[3:2]==2'b11.
REQ-007 SHALL have port result  output  DATA_WIDTH  combinational single-cycle result.
REQ-008 SHALL have port zero  output  1  high when result is all zeros.
REQ-009 SHALL have port overflow  output  1  signed overflow of ADD/SUB.
REQ-010 SHALL have port busy  output  1  multi-cycle unit occupied.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports hi, lo  output  DATA_WIDTH  registered multiply/divide results.

Function
REQ-013 SHALL decode op: 0000 AND, 0001 OR, 0010 ADD, 0011 SLT (signed), 0100 XOR, 0101 NOR, 0110 SUB, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1011 reserved (result 0), 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
REQ-014 SHALL compute codes 0000-1011 combinationally, with no clock dependency; codes 11xx SHALL drive result 0.
REQ-015 SHALL take the shift amount from b[log2(DATA_WIDTH)-1:0]; the upper bits of b SHALL be ignored.
REQ-016 SHALL produce SLT/SLTU results as 0 or 1, zero-extended.
REQ-017 SHALL assert overflow only for ADD/SUB when operand signs make the signed result wrap; overflow SHALL be 0 for all other ops.
REQ-018 SHALL implement FSM states IDLE, RUN and DONE; busy SHALL be high whenever the state is not IDLE.
REQ-019 IDLE->RUN SHALL occur when start=1 and op[3:2]==2'b11 are sampled; the FSM SHALL latch operands, op and signs, and load the step counter with DATA_WIDTH.
REQ-020 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring for divide; it SHALL operate on magnitudes for the signed ops.
REQ-021 RUN->DONE SHALL occur after exactly DATA_WIDTH RUN cycles; the FSM SHALL apply the sign correction and write hi/lo on that edge.
REQ-022 DONE SHALL last one cycle with done=1 and SHALL return to IDLE; done is therefore high DATA_WIDTH+1 cycles after the start edge.
REQ-023 MULT/MULTU SHALL write hi to the upper half and lo to the lower half of the 2*DATA_WIDTH product.
REQ-024 DIV/DIVU SHALL write lo to the quotient, truncated toward zero, and hi to the remainder, which takes the sign of the dividend.
REQ-025 Divide by zero SHALL still take the full latency, with lo=all ones and hi=a.
REQ-026 DIV of most-negative by -1 SHALL give lo=most-negative and hi=0, with no flag.
REQ-027 start SHALL be ignored while busy, and when op[3:2]!=2'b11.
REQ-028 hi/lo SHALL hold their value between completions; the combinational ops SHALL remain usable while busy.

Reset
REQ-029 rst_n low SHALL force: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, and clear internal operand registers.
REQ-030 Reset asserted mid-operation SHALL abort the operation, with no hi/lo write and no done pulse.

Configuration
REQ-031 With macro SEQ_ALU_DIV_EN defined, DIV/DIVU SHALL be implemented per REQ-024..026.
REQ-032 Without SEQ_ALU_DIV_EN, no divide logic SHALL exist, and start with op 1110/1111 SHALL be ignored: FSM stays IDLE, busy 0, hi/lo unchanged.

Verification (DATA_WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow 1, zero 0; SUB a=5 b=5 -> result 0, zero 1, overflow 0.
REQ-034 SRA a=0x80000000 b=0x24 -> 0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
REQ-035 MULT a=0xFFFFFFFD b=7 with start -> busy for 33 cycles, done in cycle 33, hi=0xFFFFFFFF lo=0xFFFFFFEB; MULTU same operands -> hi=6 lo=0xFFFFFFEB.
REQ-036 DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=9 b=0 -> lo=0xFFFFFFFF hi=9; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-037 Second start at cycle 5 of a MULT -> ignored, single done pulse; rst_n low at cycle 10 -> busy 0 and hi/lo 0 immediately, no done afterwards.
REQ-038 Build without SEQ_ALU_DIV_EN, DIV start -> busy stays 0 for 40 cycles and hi/lo unchanged; MULT still completes per REQ-035.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle combinational ops plus a radix-2 multi-cycle multiply/divide unit.
// Define SEQ_ALU_DIV_EN to build the divide path (DIV/DIVU); without it only MULT/MULTU launch.
module seq_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            op,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [W:0]      acc, acc_nx;
  logic [W-1:0]    mq, mq_nx;
  logic [W-1:0]    mcand;
  logic            neg_q;
  logic [SW-1:0]   shamt;
  logic [W-1:0]    sum, diff;
  logic            go;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      addend;
  logic [2*W-1:0]  prod_mag, prod;
`ifdef SEQ_ALU_DIV_EN
  logic            is_div;
  logic            neg_r;
  logic [W:0]      shifted, trial;
  logic [W-1:0]    rem_mag, quo, rem;
`endif

  // Combinational datapath
  assign shamt = b[SW-1:0];

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    result   = '0;
    overflow = 1'b0;
    case (op)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: begin
        result   = sum;
        overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      4'b0011: result[0] = $signed(a) < $signed(b);
      4'b0100: result = a ^ b;
      4'b0101: result = ~(a | b);
      4'b0110: begin
        result   = diff;
        overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      4'b0111: result[0] = a < b;
      4'b1000: result = a << shamt;
      4'b1001: result = a >> shamt;
      4'b1010: result = $signed(a) >>> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Launch control
`ifdef SEQ_ALU_DIV_EN
  assign go = start && (op[3:2] == 2'b11);
`else
  assign go = start && (op[3:1] == 3'b110);
`endif

  // Signed ops work on magnitudes; the sign is restored on the final edge
  assign a_neg = ~op[0] & a[W-1];
  assign b_neg = ~op[0] & b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = RUN;
      RUN:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One radix-2 step: acc/mq form a shared double-width shift register
  always_comb begin
    acc_nx = acc;
    mq_nx  = mq;
    addend = '0;
`ifdef SEQ_ALU_DIV_EN
    shifted = '0;
    trial   = '0;
    if (is_div) begin
      shifted = {acc[W-1:0], mq[W-1]};
      trial   = shifted - {1'b0, mcand};
      if (shifted >= {1'b0, mcand}) begin
        acc_nx = trial;
        mq_nx  = {mq[W-2:0], 1'b1};
      end else begin
        acc_nx = shifted;
        mq_nx  = {mq[W-2:0], 1'b0};
      end
    end else
`endif
    begin
      addend = acc + (mq[0] ? {1'b0, mcand} : '0);
      acc_nx = {1'b0, addend[W:1]};
      mq_nx  = {addend[0], mq[W-1:1]};
    end
  end

  assign prod_mag = {acc_nx[W-1:0], mq_nx};
  assign prod     = neg_q ? -prod_mag : prod_mag;
`ifdef SEQ_ALU_DIV_EN
  assign rem_mag  = acc_nx[W-1:0];
  assign quo      = neg_q ? -mq_nx : mq_nx;
  assign rem      = neg_r ? -rem_mag : rem_mag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef SEQ_ALU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (go) begin
          cnt   <= CW'(W);
          acc   <= '0;
          mq    <= a_mag;
          mcand <= b_mag;
          // Divide by zero keeps an unsigned all-ones quotient
          neg_q <= (a_neg ^ b_neg) && (b != '0);
`ifdef SEQ_ALU_DIV_EN
          is_div <= op[1];
          neg_r  <= a_neg;
`endif
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          acc <= acc_nx;
          mq  <= mq_nx;
          if (cnt == CW'(1)) begin
`ifdef SEQ_ALU_DIV_EN
            if (is_div) begin
              hi <= rem;
              lo <= quo;
            end else
`endif
            begin
              hi <= prod[2*W-1:W];
              lo <= prod[W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (DATA_WIDTH=32): directed and random stimulus
// against a plain-arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        start = 1'b0;
  logic [31:0] result, hi, lo;
  logic        zero, overflow, busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  seq_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void comb_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic ov);
    longint sx, sy, s;
    logic [4:0] sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    s  = 0;
    r  = '0;
    ov = 1'b0;
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  begin s = sx + sy; r = s[31:0]; ov = (s != longint'($signed(r))); end
      4'd3:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd4:  r = x ^ y;
      4'd5:  r = ~(x | y);
      4'd6:  begin s = sx - sy; r = s[31:0]; ov = (s != longint'($signed(r))); end
      4'd7:  r = (x < y) ? 32'd1 : 32'd0;
      4'd8:  r = x << sh;
      4'd9:  r = x >> sh;
      4'd10: r = $signed(x) >>> sh;
      default: r = '0;
    endcase
  endfunction

  function automatic void mc_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic ok, output logic [31:0] eh, output logic [31:0] el);
    longint          sx, sy, p, q, rr;
    longint unsigned pu, qu, ru;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`ifdef SEQ_ALU_DIV_EN
    ok = 1'b1;
`else
    ok = !o[1];
`endif
    eh = '0;
    el = '0;
    case (o[1:0])
      2'd0: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin pu = {32'd0, x} * {32'd0, y}; eh = pu[63:32]; el = pu[31:0]; end
      2'd2: begin
        if (y == 0) begin el = '1; eh = x; end
        else begin q = sx / sy; rr = sx % sy; el = q[31:0]; eh = rr[31:0]; end
      end
      default: begin
        if (y == 0) begin el = '1; eh = x; end
        else begin qu = {32'd0, x} / {32'd0, y}; ru = {32'd0, x} % {32'd0, y}; el = qu[31:0]; eh = ru[31:0]; end
      end
    endcase
  endfunction

  task automatic check_comb(input string tag);
    logic [31:0] r;
    logic        ov;
    #1;
    comb_ref(op, a, b, r, ov);
    check({tag, " result"}, result, r);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, (r == 32'd0)});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  task automatic comb_exp(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ez, input logic eov);
    @(negedge clk);
    op = o; a = x; b = y;
    #1;
    check({tag, " result"}, result, er);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, ez});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eov});
  endtask

  task automatic run_mc(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int restart_cyc, input int rst_cyc);
    logic        ok;
    logic [31:0] eh, el;
    int          busy_n, done_n, done_at;
    bit          aborted;
    mc_ref(o, x, y, ok, eh, el);
    busy_n = 0; done_n = 0; done_at = 0; aborted = 0;
    @(negedge clk);
    a = x; b = y; op = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check({tag, " abort busy"}, {31'd0, busy}, 32'd0);
        check({tag, " abort done"}, {31'd0, done}, 32'd0);
        check({tag, " abort hi"}, hi, 32'd0);
        check({tag, " abort lo"}, lo, 32'd0);
        rst_n = 1'b1;
        aborted = 1;
        m_hi = '0;
        m_lo = '0;
      end else begin
        if (busy) busy_n++;
        if (done) begin
          done_n++;
          if (done_at == 0) done_at = cyc;
        end
      end
      if (cyc == restart_cyc) begin
        op = 4'b1100; a = $urandom; b = $urandom; start = 1'b1;
      end else begin
        start = 1'b0; op = 4'($urandom_range(0, 11)); a = $urandom; b = $urandom;
      end
      check_comb({tag, " comb while running"});
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (aborted) begin
      check({tag, " done after abort"}, 32'(done_n), 32'd0);
      check({tag, " hi after abort"}, hi, 32'd0);
      check({tag, " lo after abort"}, lo, 32'd0);
    end else if (ok) begin
      check({tag, " done cycle"}, 32'(done_at), 32'd33);
      check({tag, " busy cycles"}, 32'(busy_n), 32'd33);
      check({tag, " done pulses"}, 32'(done_n), 32'd1);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      m_hi = eh;
      m_lo = el;
    end else begin
      check({tag, " ignored busy"}, 32'(busy_n), 32'd0);
      check({tag, " ignored done"}, 32'(done_n), 32'd0);
      check({tag, " ignored hi"}, hi, m_hi);
      check({tag, " ignored lo"}, lo, m_lo);
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed combinational vectors
    comb_exp("add ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
    comb_exp("sub zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    comb_exp("sub ovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);
    comb_exp("sra", 4'b1010, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1'b0);
    comb_exp("slt", 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    comb_exp("sltu", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    comb_exp("sll", 4'b1000, 32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1'b0, 1'b0);
    comb_exp("srl", 4'b1001, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0);
    comb_exp("nor", 4'b0101, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0);
    comb_exp("reserved", 4'b1011, 32'h12345678, 32'h9, 32'd0, 1'b1, 1'b0);
    comb_exp("mult code comb", 4'b1100, 32'h12345678, 32'h9, 32'd0, 1'b1, 1'b0);

    // Random combinational vectors, all op codes
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      check_comb("rand comb");
    end

    // Multiply
    run_mc("mult", 4'b1100, 32'hFFFFFFFD, 32'd7, 0, 0);
    check("mult hi const", hi, 32'hFFFFFFFF);
    check("mult lo const", lo, 32'hFFFFFFEB);
    run_mc("multu", 4'b1101, 32'hFFFFFFFD, 32'd7, 0, 0);
    check("multu hi const", hi, 32'd6);
    check("multu lo const", lo, 32'hFFFFFFEB);
    run_mc("mult minneg", 4'b1100, 32'h80000000, 32'h80000000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_mc("rand mult", 4'b1100, $urandom, $urandom, 0, 0);
      run_mc("rand multu", 4'b1101, $urandom, $urandom, 0, 0);
    end

    // Divide (present only in the SEQ_ALU_DIV_EN build)
`ifdef SEQ_ALU_DIV_EN
    run_mc("div neg", 4'b1110, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div neg lo const", lo, 32'hFFFFFFFD);
    check("div neg hi const", hi, 32'hFFFFFFFF);
    run_mc("divu by zero", 4'b1111, 32'd9, 32'd0, 0, 0);
    check("divu0 lo const", lo, 32'hFFFFFFFF);
    check("divu0 hi const", hi, 32'd9);
    run_mc("div by zero neg", 4'b1110, 32'hFFFFFFF0, 32'd0, 0, 0);
    run_mc("div minneg", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div minneg lo const", lo, 32'h80000000);
    check("div minneg hi const", hi, 32'd0);
    for (int i = 0; i < 3; i++) begin
      run_mc("rand div", 4'b1110, $urandom, 32'($urandom_range(1, 1000)) ^ (($urandom & 1) != 0 ? 32'hFFFFFFFF : 32'd0), 0, 0);
      run_mc("rand divu", 4'b1111, $urandom, $urandom >> $urandom_range(0, 31), 0, 0);
    end
`else
    run_mc("div disabled", 4'b1110, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_mc("divu disabled", 4'b1111, 32'd9, 32'd0, 0, 0);
`endif

    // Second start while busy is ignored
    run_mc("restart ignored", 4'b1100, $urandom, $urandom, 5, 0);

    // Reset mid-operation aborts
    run_mc("abort", 4'b1101, 32'hDEADBEEF, 32'h12345, 0, 10);

    // Unit recovers after the abort
    run_mc("post abort mult", 4'b1100, $urandom, $urandom, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
